// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
//  Shared definitions for the modulo/saturating counter family.
//  - DIR_UP / DIR_DOWN : values of the direction input.
//  - clamp_to_max      : limits a value to an upper bound (used on load).
// ----------------------------------------------------------------------------
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // 32-bit wide so any counter up to 32 bits can share one helper.
    function automatic logic [31:0] clamp_to_max(input logic [31:0] value,
                                                 input logic [31:0] max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// ----------------------------------------------------------------------------
// mod_counter
//  Parametrised modulo up/down counter counting 0..MAX with enable, direction,
//  synchronous parallel load and a registered wrap pulse.
//
//  Parameters
//    WIDTH  counter width in bits (>= 1, <= 32)
//    MAX    terminal value, count range 0..MAX (MAX <= 2**WIDTH-1)
//
//  Ports
//    clk     in   rising-edge clock
//    rstn    in   synchronous reset, active HIGH (1 = reset)
//    en      in   count enable
//    up      in   direction: 1 = increment, 0 = decrement
//    load    in   synchronous load strobe (beats en)
//    din     in   load value, clamped to MAX
//    out     out  current count (registered)
//    wrap    out  one-cycle pulse: previous edge wrapped (or saturated)
//    at_max  out  out == MAX (combinational)
//    at_min  out  out == 0   (combinational)
//
//  Configuration
//    MOD_COUNTER_SATURATE_EN  defined: hold at the limits instead of wrapping;
//                             wrap then flags every enabled edge attempted at
//                             a limit. Undefined: modulo wrap-around.
// ----------------------------------------------------------------------------
module mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;

    // Limits are detected by compare, not carry-out, so any MAX works.
    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        if (load) begin
            out_d = WIDTH'(clamp_to_max(32'(din), 32'(MAX)));
        end else if (en) begin
            if (up == DIR_UP) begin
                if (out_q == MaxVal) begin
`ifdef MOD_COUNTER_SATURATE_EN
                    out_d = MaxVal;
`else
                    out_d = '0;
`endif
                    wrap_d = 1'b1;
                end else begin
                    out_d = out_q + One;
                end
            end else begin
                if (out_q == '0) begin
`ifdef MOD_COUNTER_SATURATE_EN
                    out_d = '0;
`else
                    out_d = MaxVal;
`endif
                    wrap_d = 1'b1;
                end else begin
                    out_d = out_q - One;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            out_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign out    = out_q;
    assign wrap   = wrap_q;
    assign at_max = (out_q == MaxVal);
    assign at_min = (out_q == '0);

endmodule
